// File: rtl/dotp_pkg.sv
// Shared types, constants and helpers for the dot-product sequencer.
// Optional build macro: DOTP_SATURATE_EN selects saturating result reduction
// (0xFF when the sum exceeds 255); otherwise the result is truncated modulo 256.
package dotp_pkg;

  localparam int DATA_W  = 8;
  localparam int VEC_LEN = 8;
  localparam int ADDR_W  = 4;
  localparam int A_BASE  = 0;
  localparam int B_BASE  = 8;

  // Accumulator wide enough to hold VEC_LEN full-scale products.
  function automatic int calc_acc_w(input int data_w, input int vec_len);
    return 2 * data_w + $clog2(vec_len);
  endfunction

  localparam int ACC_W = calc_acc_w(DATA_W, VEC_LEN);

  localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'({DATA_W{1'b1}});

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_READ_A = 3'd2,
    ST_READ_B = 3'd3,
    ST_ACC    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Fold the accumulator down to a result byte.
  function automatic logic [DATA_W-1:0] reduce_acc(input logic [ACC_W-1:0] acc);
`ifdef DOTP_SATURATE_EN
    if (acc > SAT_LIMIT) begin
      return {DATA_W{1'b1}};
    end else begin
      return acc[DATA_W-1:0];
    end
`else
    return acc[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/dotp_mac.sv
// Multiply-accumulate register: acc <= acc + a*b when enabled, cleared on clr.
module dotp_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);

  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    sum_s;
  logic [ACC_W-1:0]    acc_r;

  // Unsigned product zero-extended into the accumulator width.
  always_comb begin
    prod_s = a * b;
    sum_s  = acc_r + {{(ACC_W-2*DATA_W){1'b0}}, prod_s};
  end

  // Accumulator register with clear taking priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;
  assign sum = sum_s;

endmodule

// File: rtl/dotp_sequencer.sv
// Dot-product sequencer: arbitrates for the operand memory, reads A[i] then
// B[i] for each element, accumulates the products and reports the reduced sum.
// Optional build macro: DOTP_SATURATE_EN (see dotp_pkg::reduce_acc).
module dotp_sequencer #(
  parameter int DATA_W  = dotp_pkg::DATA_W,
  parameter int VEC_LEN = dotp_pkg::VEC_LEN,
  parameter int ADDR_W  = dotp_pkg::ADDR_W,
  parameter int B_BASE  = dotp_pkg::B_BASE,
  parameter int ACC_W   = dotp_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              comp_start,
  output logic              comp_done,
  output logic [DATA_W-1:0] comp_result,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  import dotp_pkg::*;

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  state_t              state_r;
  state_t              next_s;
  logic [IDX_W-1:0]    index_r;
  logic [DATA_W-1:0]   a_r;
  logic                a_issued_r;
  logic [DATA_W-1:0]   comp_result_r;
  logic                mem_req_s;
  logic                mem_rd_en_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                mac_clr_s;
  logic                mac_en_s;
  logic                last_s;
  logic [ACC_W-1:0]    acc_s;
  logic [ACC_W-1:0]    mac_sum_s;

  assign last_s = (index_r == LAST_IDX);

  dotp_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr_s),
    .en  (mac_en_s),
    .a   (a_r),
    .b   (mem_rd_data),
    .acc (acc_s),
    .sum (mac_sum_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode and memory-port / MAC control.
  always_comb begin
    next_s      = state_r;
    mem_req_s   = 1'b0;
    mem_rd_en_s = 1'b0;
    mem_addr_s  = '0;
    mac_clr_s   = 1'b0;
    mac_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (comp_start) begin
          next_s    = ST_REQ;
          mac_clr_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        mem_req_s = 1'b1;
        if (mem_gnt) begin
          next_s = ST_READ_A;
        end else begin
          next_s = ST_REQ;
        end
      end
      ST_READ_A: begin
        mem_req_s   = 1'b1;
        mem_addr_s  = ADDR_W'(A_BASE) + ADDR_W'(index_r);
        mem_rd_en_s = mem_gnt;
        if (mem_gnt) begin
          next_s = ST_READ_B;
        end else begin
          next_s = ST_READ_A;
        end
      end
      ST_READ_B: begin
        mem_req_s   = 1'b1;
        mem_addr_s  = ADDR_W'(B_BASE) + ADDR_W'(index_r);
        mem_rd_en_s = mem_gnt;
        if (mem_gnt) begin
          next_s = ST_ACC;
        end else begin
          next_s = ST_READ_B;
        end
      end
      ST_ACC: begin
        mem_req_s = 1'b1;
        mac_en_s  = 1'b1;
        if (last_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_READ_A;
        end
      end
      ST_DONE: begin
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // Element index, A operand capture and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_r       <= '0;
      a_r           <= '0;
      a_issued_r    <= 1'b0;
      comp_result_r <= '0;
    end else begin
      a_issued_r <= (state_r == ST_READ_A) && mem_gnt;
      if (a_issued_r) begin
        a_r <= mem_rd_data;
      end else begin
        a_r <= a_r;
      end
      if ((state_r == ST_IDLE) && comp_start) begin
        index_r <= '0;
      end else if ((state_r == ST_ACC) && !last_s) begin
        index_r <= index_r + IDX_W'(1);
      end else begin
        index_r <= index_r;
      end
      // Load with the final sum so the result is valid during the done pulse.
      if ((state_r == ST_ACC) && last_s) begin
        comp_result_r <= reduce_acc(mac_sum_s);
      end else begin
        comp_result_r <= comp_result_r;
      end
    end
  end

  assign comp_done   = (state_r == ST_DONE);
  assign busy        = (state_r != ST_IDLE);
  assign comp_result = comp_result_r;
  assign mem_req     = mem_req_s;
  assign mem_rd_en   = mem_rd_en_s;
  assign mem_addr    = mem_addr_s;

endmodule

// File: tb/tb_dotp_sequencer.sv
// Self-checking bench for dotp_sequencer: vector table plus random operands.
module tb_dotp_sequencer;

  localparam int HORIZON = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       comp_start = 1'b0;
  logic       comp_done;
  logic [7:0] comp_result;
  logic       mem_req;
  logic       mem_gnt = 1'b1;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       busy;

  logic [7:0] mem [16];
  int         addr_q[$];
  int         bad_rd;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    logic [63:0] a_vec;
    logic [63:0] b_vec;
    int          stall_s;
    int          stall_n;
    int          again_k;
    int          exp_done;
    logic [7:0]  exp_trunc;
    logic [7:0]  exp_sat;
  } vec_t;

  vec_t tbl [5];

  dotp_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .comp_start  (comp_start),
    .comp_done   (comp_done),
    .comp_result (comp_result),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Memory model: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      addr_q.push_back(int'(mem_addr));
      if (!mem_gnt) bad_rd <= bad_rd + 1;
    end else begin
      mem_rd_data <= 8'($urandom);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_reduce(input int acc);
`ifdef DOTP_SATURATE_EN
    return (acc > 255) ? 8'hFF : 8'(acc);
`else
    return 8'(acc);
`endif
  endfunction

  task automatic load_mem(input logic [63:0] a_vec, input logic [63:0] b_vec);
    for (int i = 0; i < 8; i++) begin
      mem[i]     = a_vec[8*i +: 8];
      mem[8 + i] = b_vec[8*i +: 8];
    end
  endtask

  task automatic run_op(input int stall_s, input int stall_n, input int again_k,
                        input int rst_k, output int done_k, output int done_cnt,
                        output int busy_after, output int res);
    done_k = -1; done_cnt = 0; busy_after = 0; res = -1;
    addr_q.delete();
    bad_rd = 0;
    comp_start = 1'b1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    comp_start = 1'b0;
    for (int k = 1; k <= HORIZON; k++) begin
      mem_gnt = (k >= stall_s && k < stall_s + stall_n) ? 1'b0 : 1'b1;
      comp_start = (k == again_k) ? 1'b1 : 1'b0;
      rst = (k == rst_k) ? 1'b1 : 1'b0;
      #1;
      if (comp_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k > 0 && k > done_k && busy) busy_after++;
      if (done_k > 0 && k == done_k + 1) res = int'(comp_result);
      if (rst_k > 0 && k == rst_k + 1) begin
        check("abort_mem_req", int'(mem_req), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(comp_result), 0);
      end
      @(posedge clk); #1;
    end
    comp_start = 1'b0;
    rst = 1'b0;
    mem_gnt = 1'b1;
  endtask

  task automatic check_addr_seq();
    int bad;
    bad = 0;
    check("addr_count", addr_q.size(), 16);
    for (int j = 0; j < addr_q.size() && j < 16; j++) begin
      if (addr_q[j] != ((j % 2 == 0) ? j / 2 : 8 + j / 2)) bad++;
    end
    check("addr_order", bad, 0);
    check("rd_without_gnt", bad_rd, 0);
  endtask

  initial begin
    int dk, dc, ba, res, acc;
    logic [63:0] av, bv;

    tbl[0] = '{64'h0807060504030201, 64'h1211100F0E0D0C0B, 0, 0, 0, 26, 8'h34, 8'hFF};
    tbl[1] = '{64'h0807060504030201, 64'h0101010101010101, 1, 3, 0, 29, 8'h24, 8'h24};
    tbl[2] = '{64'h0807060504030201, 64'h1211100F0E0D0C0B, 15, 2, 0, 28, 8'h34, 8'hFF};
    tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 0, 10, 26, 8'h08, 8'hFF};
    tbl[4] = '{64'h0807060504030201, 64'h0101010101010101, 0, 0, 26, 26, 8'h24, 8'h24};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_done", int'(comp_done), 0);
    check("reset_result", int'(comp_result), 0);
    check("reset_mem_req", int'(mem_req), 0);
    check("reset_rd_en", int'(mem_rd_en), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk); #1;

    for (int r = 0; r < 5; r++) begin
      load_mem(tbl[r].a_vec, tbl[r].b_vec);
      run_op(tbl[r].stall_s, tbl[r].stall_n, tbl[r].again_k, 0, dk, dc, ba, res);
      check($sformatf("row%0d_done_cycle", r), dk, tbl[r].exp_done);
      check($sformatf("row%0d_done_count", r), dc, 1);
      check($sformatf("row%0d_idle_after", r), ba, 0);
`ifdef DOTP_SATURATE_EN
      check($sformatf("row%0d_result", r), res, int'(tbl[r].exp_sat));
`else
      check($sformatf("row%0d_result", r), res, int'(tbl[r].exp_trunc));
`endif
      check_addr_seq();
    end

    // Abort mid-run, then a fresh run must complete normally.
    load_mem(tbl[0].a_vec, tbl[0].b_vec);
    run_op(0, 0, 0, 10, dk, dc, ba, res);
    check("abort_no_done", dc, 0);
    run_op(0, 0, 0, 0, dk, dc, ba, res);
    check("rerun_done_cycle", dk, 26);
    check("rerun_result", res, int'(model_reduce(564)));

    // Random operands against an arithmetic reference.
    for (int t = 0; t < 6; t++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if (t == 0) bv = 64'h0;
      acc = 0;
      for (int i = 0; i < 8; i++) acc += int'(av[8*i +: 8]) * int'(bv[8*i +: 8]);
      load_mem(av, bv);
      run_op(0, 0, 0, 0, dk, dc, ba, res);
      check($sformatf("rand%0d_done_cycle", t), dk, 26);
      check($sformatf("rand%0d_result", t), res, int'(model_reduce(acc)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dotp_sequencer.md
Name: dotp_sequencer

Overview:
Compute-phase engine behind the system controller. On comp_start it requests the shared 16-entry operand memory, reads vector A (addr 0..7) and vector B (addr 8..15), and multiply-accumulates A[i]*B[i]. It then returns an 8-bit comp_result with a one-cycle comp_done pulse. It sits between the controller (comp_start/comp_done/comp_result) and the memory read port, which it shares with the controller through a req/gnt pair.

Parameters:
DATA_W, 8, operand and result width
VEC_LEN, 8, elements per vector
ADDR_W, 4, memory address width
B_BASE, 8, base address of vector B (A base fixed at 0)
ACC_W, 19, accumulator width (2*DATA_W + clog2(VEC_LEN))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
comp_start  in  1  start request from controller, sampled only in IDLE
comp_done  out  1  one-cycle pulse when comp_result is updated
comp_result  out  DATA_W  final result, held until next completion
mem_req  out  1  request for memory read port
mem_gnt  in  1  grant from controller/arbiter, level
mem_rd_en  out  1  read strobe
mem_addr  out  ADDR_W  read address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (one clock, rst=1) drives all outputs to 0, state to IDLE, acc to 0, index to 0. rst mid-operation aborts immediately; there is no done pulse and comp_result is cleared to 0.
- FSM states: IDLE, REQ, READ_A, READ_B, ACC, DONE.
- IDLE: comp_start=1 -> REQ; clears acc and index.
- REQ: mem_req=1; mem_gnt=1 -> READ_A.
- READ_A: mem_addr=index, mem_rd_en=mem_gnt. Advances to READ_B only when mem_gnt=1.
- READ_B: mem_addr=B_BASE+index, mem_rd_en=mem_gnt. Advances to ACC only when mem_gnt=1.
- a_reg loads mem_rd_data in the cycle after an A read was actually issued, independent of state.
- ACC: acc <= acc + a_reg*mem_rd_data (B data arrives this cycle); no memory access. If index==VEC_LEN-1 -> DONE, else index+1 and -> READ_A.
- DONE: comp_result <= reduce(acc), comp_done=1 for this single cycle; -> IDLE.
- mem_req is high from REQ through the final ACC and low in IDLE and DONE.
- Loss of mem_gnt stalls READ_A/READ_B with mem_rd_en=0; the read is reissued when the grant returns. An already-issued read still captures its data.
- Latency with mem_gnt tied high: comp_done is high in the 26th cycle after the edge that sampled comp_start (1 REQ + 24 element cycles + DONE). Each stalled cycle adds 1.
- comp_start while busy is ignored. comp_start in the cycle DONE is active is also ignored; it is sampled on the next cycle in IDLE.
- Arithmetic is unsigned. The product is 2*DATA_W bits zero-extended to ACC_W. The accumulator cannot overflow for the default parameters.

Optional Feature:
DOTP_SATURATE_EN
- Defined: reduce(acc) = 8'hFF if acc > 255, else acc[7:0].
- Undefined: reduce(acc) = acc[DATA_W-1:0] (truncation, modulo 256).

Decomposition:
- Package dotp_pkg: FSM state enum, B_BASE/A_BASE constants, ACC_W derivation function, reduce() helper.
- One sub-module, dotp_mac: registered acc with clear and enable, computing acc + a*b. The FSM and address generation stay in dotp_sequencer.

Test Plan:
- Memory A=1..8, B=11..18, gnt tied high -> comp_done 26 cycles after start; comp_result=0xFF with DOTP_SATURATE_EN, 0x34 (564 mod 256) without.
- A=1..8, B all 1 -> comp_result=0x24 in both builds; mem_addr sequence exactly 0,8,1,9,...,7,15.
- gnt held low 3 cycles after mem_req rises, then high -> comp_done at 29 cycles; result unchanged.
- gnt dropped 2 cycles while in READ_B of element 4 -> no mem_rd_en during drop, read reissued, result correct, done delayed 2 cycles.
- All operands 0xFF -> acc=520200; comp_result=0xFF (sat) / 0x08 (trunc). A second comp_start pulsed mid-run is ignored, giving exactly one comp_done.
- rst asserted at cycle 10 of a run -> next cycle IDLE, mem_req=0, comp_result=0, no comp_done; a fresh start then completes normally.
